// File: rtl/mux_scan_ctrl_if.sv
// Result-word channel from the scan controller to its consumer.
// Handshake: word/word_valid are driven by the master, word_ready by the slave; a word
// transfers on any rising clock edge where word_valid and word_ready are both 1, and the
// master holds word stable for as long as word_valid stays 1.
interface mux_scan_ctrl_if #(
  parameter int CH = 8
);
  logic [CH-1:0] word;
  logic          word_valid;
  logic          word_ready;

  modport master (
    output word,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Select sequencer and capture stage for an 8:1 mux: steps the select, samples y per
// channel after a settle window and hands the assembled word downstream.
module mux_scan_ctrl #(
  parameter  int NSEL   = 3,
  parameter  int SETTLE = 1,
  localparam int CH     = 2 ** NSEL
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cont,
  input  logic            clr,
  input  logic            y,
  output logic [NSEL-1:0] s,
  output logic            busy,
  output logic            overrun,
  output logic [1:0]      state_dbg,
  mux_scan_ctrl_if.master wb
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  // With no settle window a channel is sampled one cycle after its select is driven.
  localparam state_t     FIRST_ST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);
  localparam logic [NSEL-1:0] LAST_CH = NSEL'(CH - 1);

  state_t          state_q, state_d;
  logic [NSEL-1:0] s_q, s_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [CH-1:0]   shadow_q, shadow_d;
  logic [CH-1:0]   word_q, word_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;

  logic            last_ch;
  logic            can_commit;

  assign last_ch    = (s_q == LAST_CH);
  // The slot is free if empty, or if the current word leaves on this very edge.
  assign can_commit = !valid_q || wb.word_ready;

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    shadow_d  = shadow_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (clr) begin
      overrun_d = 1'b0;
    end
    if (valid_q && wb.word_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = FIRST_ST;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if ((cnt_q + 4'd1) == SETTLE_C) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        shadow_d[s_q] = y;
        cnt_d         = '0;
        if (!last_ch) begin
          s_d     = s_q + NSEL'(1);
          state_d = FIRST_ST;
        end else begin
          // The final channel bypasses the shadow so it lands in the word on this edge.
          if (can_commit) begin
            word_d  = {y, shadow_q[CH-2:0]};
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          s_d = '0;
          if (cont) begin
            state_d = FIRST_ST;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      shadow_q  <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      shadow_q  <= shadow_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign s             = s_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;
  assign state_dbg     = state_q;
  assign wb.word       = word_q;
  assign wb.word_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance with SETTLE=1, one with SETTLE=0,
// each fed by a behavioural 8:1 mux model.
module tb_mux_scan_ctrl;

  logic clk;
  logic rst_n;
  logic cont;
  logic clr;

  logic       start1, start0;
  logic [7:0] i1, i0;
  logic       y1, y0;
  logic       yforce_en, yforce;
  logic [2:0] s1, s0;
  logic       busy1, busy0;
  logic       ovr1, ovr0;
  logic [1:0] st1, st0;

  int n_checks;
  int n_fail;

  mux_scan_ctrl_if #(.CH(8)) if1 ();
  mux_scan_ctrl_if #(.CH(8)) if0 ();

  mux_scan_ctrl #(.NSEL(3), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont), .clr(clr), .y(y1),
    .s(s1), .busy(busy1), .overrun(ovr1), .state_dbg(st1), .wb(if1)
  );

  mux_scan_ctrl #(.NSEL(3), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont), .clr(clr), .y(y0),
    .s(s0), .busy(busy0), .overrun(ovr0), .state_dbg(st0), .wb(if0)
  );

  // Mux model; the override lets a scenario put junk on y during settle cycles.
  assign y1 = yforce_en ? yforce : i1[s1];
  assign y0 = i0[s0];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (s1 !== 3'd0 || busy1 !== 1'b0 || if1.word_valid !== 1'b0 || if1.word !== 8'h00 || ovr1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut1 s=%0d busy=%b valid=%b word=%h ovr=%b exp all zero", s1, busy1, if1.word_valid, if1.word, ovr1);
    end
    n_checks++;
    if (s0 !== 3'd0 || busy0 !== 1'b0 || if0.word_valid !== 1'b0 || if0.word !== 8'h00 || ovr0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut0 s=%0d busy=%b valid=%b word=%h ovr=%b exp all zero", s0, busy0, if0.word_valid, if0.word, ovr0);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start1();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic test_single_scan();
    i1 = 8'hA5;
    cont = 1'b0;
    if1.word_ready = 1'b1;
    pulse_start1();
    for (int c = 0; c < 16; c++) begin
      n_checks++;
      if (s1 !== 3'(c / 2) || busy1 !== 1'b1 || if1.word_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_seq c=%0d s=%0d busy=%b valid=%b exp s=%0d busy=1 valid=0", c, s1, busy1, if1.word_valid, c / 2);
      end
      @(negedge clk);
    end
    n_checks++;
    if (if1.word_valid !== 1'b1 || if1.word !== 8'hA5 || busy1 !== 1'b0 || s1 !== 3'd0) begin
      n_fail++;
      $display("FAIL single_done valid=%b word=%h busy=%b s=%0d exp 1 a5 0 0", if1.word_valid, if1.word, busy1, s1);
    end
    @(negedge clk);
    n_checks++;
    if (if1.word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_consume valid=%b exp 0", if1.word_valid);
    end
  endtask

  task automatic test_settle0();
    if0.word_ready = 1'b1;
    cont = 1'b0;
    for (int b = 0; b < 8; b++) begin
      i0 = 8'h01 << b;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (7) @(negedge clk);
      n_checks++;
      if (if0.word_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL settle0_early b=%0d valid=%b exp 0", b, if0.word_valid);
      end
      @(negedge clk);
      n_checks++;
      if (if0.word_valid !== 1'b1 || if0.word !== (8'h01 << b) || busy0 !== 1'b0) begin
        n_fail++;
        $display("FAIL settle0_word b=%0d valid=%b word=%h busy=%b exp 1 %h 0", b, if0.word_valid, if0.word, busy0, 8'h01 << b);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overrun();
    i1 = 8'h3C;
    cont = 1'b1;
    if1.word_ready = 1'b0;
    pulse_start1();
    repeat (16) @(negedge clk);
    n_checks++;
    if (if1.word_valid !== 1'b1 || if1.word !== 8'h3C || busy1 !== 1'b1 || ovr1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first valid=%b word=%h busy=%b ovr=%b exp 1 3c 1 0", if1.word_valid, if1.word, busy1, ovr1);
    end
    i1 = 8'hFF;
    repeat (8) @(negedge clk);
    cont = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (if1.word_valid !== 1'b1 || if1.word !== 8'h3C || ovr1 !== 1'b1 || busy1 !== 1'b0 || st1 !== 2'd0) begin
      n_fail++;
      $display("FAIL ovr_second valid=%b word=%h ovr=%b busy=%b st=%0d exp 1 3c 1 0 0", if1.word_valid, if1.word, ovr1, busy1, st1);
    end
    if1.word_ready = 1'b1;
    @(negedge clk);
    if1.word_ready = 1'b0;
    n_checks++;
    if (if1.word_valid !== 1'b0 || ovr1 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_take valid=%b ovr=%b exp 0 1", if1.word_valid, ovr1);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (ovr1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clr ovr=%b exp 0", ovr1);
    end
  endtask

  task automatic test_back_to_back();
    i1 = 8'h5A;
    cont = 1'b1;
    if1.word_ready = 1'b0;
    pulse_start1();
    repeat (16) @(negedge clk);
    n_checks++;
    if (if1.word_valid !== 1'b1 || if1.word !== 8'h5A) begin
      n_fail++;
      $display("FAIL b2b_first valid=%b word=%h exp 1 5a", if1.word_valid, if1.word);
    end
    i1 = 8'hC3;
    for (int c = 17; c < 32; c++) begin
      @(negedge clk);
      n_checks++;
      if (if1.word_valid !== 1'b1 || if1.word !== 8'h5A) begin
        n_fail++;
        $display("FAIL b2b_hold c=%0d valid=%b word=%h exp 1 5a", c, if1.word_valid, if1.word);
      end
    end
    if1.word_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if1.word_valid !== 1'b1 || if1.word !== 8'hC3 || ovr1 !== 1'b0 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_reload valid=%b word=%h ovr=%b busy=%b exp 1 c3 0 1", if1.word_valid, if1.word, ovr1, busy1);
    end
    i1 = 8'hE7;
    cont = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if1.word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain valid=%b exp 0", if1.word_valid);
    end
    repeat (15) @(negedge clk);
    n_checks++;
    if (if1.word_valid !== 1'b1 || if1.word !== 8'hE7 || ovr1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_third valid=%b word=%h ovr=%b busy=%b exp 1 e7 0 0", if1.word_valid, if1.word, ovr1, busy1);
    end
  endtask

  task automatic test_reset_mid_scan();
    i1 = 8'h11;
    cont = 1'b0;
    if1.word_ready = 1'b1;
    pulse_start1();
    repeat (6) @(negedge clk);
    n_checks++;
    if (s1 !== 3'd3 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre s=%0d busy=%b exp 3 1", s1, busy1);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (s1 !== 3'd0 || busy1 !== 1'b0 || if1.word !== 8'h00 || if1.word_valid !== 1'b0 || st1 !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_now s=%0d busy=%b word=%h valid=%b st=%0d exp all zero", s1, busy1, if1.word, if1.word_valid, st1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i1 = 8'h96;
    pulse_start1();
    repeat (16) @(negedge clk);
    n_checks++;
    if (if1.word_valid !== 1'b1 || if1.word !== 8'h96 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_after valid=%b word=%h busy=%b exp 1 96 0", if1.word_valid, if1.word, busy1);
    end
    @(negedge clk);
  endtask

  task automatic test_start_busy_glitch();
    i1 = 8'h69;
    cont = 1'b0;
    if1.word_ready = 1'b1;
    yforce_en = 1'b1;
    yforce = 1'b0;
    pulse_start1();
    for (int c = 0; c < 16; c++) begin
      n_checks++;
      if (s1 !== 3'(c / 2)) begin
        n_fail++;
        $display("FAIL glitch_seq c=%0d s=%0d exp %0d", c, s1, c / 2);
      end
      // Even cycles are settle cycles: drive the wrong value there.
      yforce = (c % 2 == 0) ? ~i1[c / 2] : i1[c / 2];
      if (c == 5) start1 = 1'b1;
      if (c == 6) start1 = 1'b0;
      @(negedge clk);
    end
    yforce_en = 1'b0;
    n_checks++;
    if (if1.word_valid !== 1'b1 || if1.word !== 8'h69 || busy1 !== 1'b0 || s1 !== 3'd0) begin
      n_fail++;
      $display("FAIL glitch_word valid=%b word=%h busy=%b s=%0d exp 1 69 0 0", if1.word_valid, if1.word, busy1, s1);
    end
    @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0 || st1 !== 2'd0) begin
      n_fail++;
      $display("FAIL glitch_norestart busy=%b st=%0d exp 0 0", busy1, st1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    cont = 1'b0;
    clr = 1'b0;
    start1 = 1'b0;
    start0 = 1'b0;
    i1 = 8'h00;
    i0 = 8'h00;
    yforce_en = 1'b0;
    yforce = 1'b0;
    if1.word_ready = 1'b0;
    if0.word_ready = 1'b0;

    test_reset();
    test_single_scan();
    test_settle0();
    test_overrun();
    test_back_to_back();
    test_reset_mid_scan();
    test_start_busy_glitch();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
